// File: rtl/crc_pkg.sv
// Shared CRC definitions: stream FSM states and common polynomial presets.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_e;

    localparam logic [7:0]  CRC8  = 8'h07;
    localparam logic [31:0] CRC32 = 32'h04C11DB7;

endpackage

// File: rtl/crc_gen_p.sv
// Combinational parallel CRC: folds one DW-bit beat (MSB first) into crc_in.
module crc_gen_p #(
    parameter int            DW   = 8,
    parameter int            CW   = 8,
    parameter logic [CW-1:0] POLY = 'h07
) (
    input  logic [DW-1:0] data_in,
    input  logic [CW-1:0] crc_in,
    output logic [CW-1:0] crc_out
);

    // Unrolled bit-serial LFSR; synthesis flattens it into an XOR network.
    always_comb begin
        logic [CW-1:0] c;
        logic          fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[CW-1] ^ data_in[i];
            c  = c << 1;
            if (fb) c = c ^ POLY;
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream.sv
// Packetised streaming CRC: accumulates sop..eop beats, holds the result
// until the consumer takes it, and flags broken packet framing.
module crc_stream
    import crc_pkg::*;
#(
    parameter int            DW     = 8,
    parameter int            CW     = 8,
    parameter logic [CW-1:0] POLY   = CW'(CRC8),
    parameter logic [CW-1:0] INIT   = '0,
    parameter logic [CW-1:0] XOROUT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sop,
    input  logic          s_eop,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] m_crc,
    output logic          err_framing
);

    crc_state_e    state;
    logic [CW-1:0] crc_reg;
    logic [CW-1:0] seed;
    logic [CW-1:0] crc_next;
    logic          accept;

    // Result is held in DONE, so input is back-pressured there.
    assign s_ready = (state != DONE);
    assign accept  = s_valid & s_ready;
    // A new packet (or a stray beat outside one) always restarts from INIT.
    assign seed    = (s_sop || state == IDLE) ? INIT : crc_reg;

    crc_gen_p #(
        .DW   (DW),
        .CW   (CW),
        .POLY (POLY)
    ) u_gen (
        .data_in (s_data),
        .crc_in  (seed),
        .crc_out (crc_next)
    );

    // Packet FSM, running CRC, registered result and framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            crc_reg     <= INIT;
            m_crc       <= '0;
            m_valid     <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            err_framing <= 1'b0;
            case (state)
                IDLE, BUSY: begin
                    if (accept) begin
                        crc_reg <= crc_next;
                        // Missing sop when idle, or a fresh sop mid-packet.
                        err_framing <= (state == IDLE) ? !s_sop : s_sop;
                        if (s_eop) begin
                            state   <= DONE;
                            m_crc   <= crc_next ^ XOROUT;
                            m_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: a CRC-8 default instance and a CRC-32 instance share
// one input stream; each is checked against a queue-based reference model.
module tb_crc_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_sop, s_eop, m_ready;
    logic [7:0]  s_data;
    logic        s_ready_a, m_valid_a, err_a;
    logic        s_ready_b, m_valid_b, err_b;
    logic [7:0]  crc_a;
    logic [31:0] crc_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pkt[$];
    logic        open = 1'b0;
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    crc_stream u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .m_valid(m_valid_a),
        .m_ready(m_ready), .m_crc(crc_a), .err_framing(err_a)
    );

    crc_stream #(
        .DW(8), .CW(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'h0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .m_valid(m_valid_b),
        .m_ready(m_ready), .m_crc(crc_b), .err_framing(err_b)
    );

    // Polynomial division of the whole packet message, MSB first.
    function automatic logic [31:0] ref_crc(input int cw, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xorout);
        longint unsigned mask, r;
        logic top;
        mask = (64'd1 << cw) - 64'd1;
        r    = {32'd0, init};
        foreach (pkt[k]) begin
            for (int b = 7; b >= 0; b--) begin
                top = r[cw-1] ^ pkt[k][b];
                r   = (r << 1) & mask;
                if (top) r = r ^ {32'd0, poly};
            end
        end
        return r[31:0] ^ xorout;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            s_data = 8'($urandom); s_sop = 1'($urandom); s_eop = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, check the aftermath.
    task automatic send(input logic [7:0] d, input logic sop, input logic eop);
        logic exp_err;
        int   n;
        exp_err = open ? sop : !sop;
        if (sop || !open) pkt.delete();
        pkt.push_back(d);
        open = !eop;
        s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
        n = 0;
        while (s_ready_a !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 8'($urandom); s_sop = 1'($urandom); s_eop = 1'($urandom);
        chk("err_a", 32'(err_a), 32'(exp_err));
        chk("err_b", 32'(err_b), 32'(exp_err));
        if (eop) begin
            exp_a = ref_crc(8, 32'h07, 32'h0, 32'h0);
            exp_b = ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0);
            chk("m_valid_a", 32'(m_valid_a), 32'd1);
            chk("m_valid_b", 32'(m_valid_b), 32'd1);
            chk("m_crc_a", 32'(crc_a), exp_a);
            chk("m_crc_b", crc_b, exp_b);
            chk("s_ready_done", 32'(s_ready_a), 32'd0);
        end
    endtask

    task automatic drain();
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid_a", 32'(m_valid_a), 32'd0);
        chk("drain_valid_b", 32'(m_valid_b), 32'd0);
        chk("drain_ready", 32'(s_ready_a), 32'd1);
        chk("drain_err", 32'(err_a), 32'd0);
    endtask

    task automatic send_check_str();
        for (int i = 0; i < 9; i++) send(8'(8'h31 + i), i == 0, i == 8);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        s_data = 8'h00; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid_a), 32'd0);
        chk("rst_m_crc", 32'(crc_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_s_ready", 32'(s_ready_a), 32'd1);
        rst_n = 1'b1;
        idle(2);

        // Check string on both CRC presets
        send_check_str();
        chk("known_crc8", 32'(crc_a), 32'hF4);
        chk("known_crc32", crc_b, 32'h0376E6E7);
        drain();

        // Single-beat packets
        send(8'h01, 1'b1, 1'b1);
        chk("single_01", 32'(crc_a), 32'h07);
        drain();
        send(8'h00, 1'b1, 1'b1);
        chk("single_00", 32'(crc_a), 32'h00);
        drain();

        // Consumer stall with input pressure
        for (int i = 0; i < 9; i++) begin
            if (i == 8) m_ready = 1'b0;
            send(8'(8'h31 + i), i == 0, i == 8);
        end
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_ready", 32'(s_ready_a), 32'd0);
            chk("stall_valid", 32'(m_valid_a), 32'd1);
            chk("stall_crc", 32'(crc_a), 32'hF4);
        end
        s_valid = 1'b0;
        drain();
        send_check_str();
        chk("after_stall", 32'(crc_a), 32'hF4);
        drain();

        // Framing errors: sop inside an open packet, then eop with no sop
        send(8'hAA, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b1);
        chk("resop_crc", 32'(crc_a), 32'h07);
        drain();
        send(8'h01, 1'b0, 1'b1);
        chk("nosop_crc", 32'(crc_a), 32'h07);
        drain();

        // Reset mid-packet abandons it
        for (int i = 0; i < 4; i++) send(8'(8'h31 + i), i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(m_valid_a), 32'd0);
        chk("midrst_ready", 32'(s_ready_a), 32'd1);
        chk("midrst_crc", 32'(crc_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pkt.delete(); open = 1'b0;
        idle(2);
        chk("midrst_no_out", 32'(m_valid_a), 32'd0);
        send_check_str();
        chk("after_rst", 32'(crc_a), 32'hF4);
        drain();

        // Randomised packets: gaps, occasional missing sop, consumer delay
        for (int p = 0; p < 12; p++) begin
            int len;
            int hold;
            len  = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                logic sop;
                sop = (i == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
                if (i == len - 1 && hold != 0) m_ready = 1'b0;
                send(8'($urandom), sop, i == len - 1);
                if (i != len - 1) idle($urandom_range(0, 2));
            end
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("rnd_hold_valid", 32'(m_valid_a), 32'd1);
                chk("rnd_hold_crc", crc_b, exp_b);
            end
            drain();
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 SHALL have parameter DW, default 8, data beat width in bits.
REQ-002 SHALL have parameter CW, default 8, CRC width in bits.
REQ-003 SHALL have parameter POLY, default 8'h07, normal-form polynomial, CW bits.
REQ-004 SHALL have parameter INIT, default 0, CRC seed applied on first beat, CW bits.
REQ-005 SHALL have parameter XOROUT, default 0, final XOR mask, CW bits.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  reset, asserted low, asynchronous.
REQ-007 SHALL have s_valid  in  1  input beat valid.
REQ-008 SHALL have s_ready  out  1  input beat accepted when s_valid & s_ready.
REQ-009 SHALL have s_data  in  DW  data beat, MSB processed first.
REQ-010 SHALL have s_sop  in  1  first beat of packet.
REQ-011 SHALL have s_eop  in  1  last beat of packet.
REQ-012 SHALL have m_valid  out  1  final CRC valid.
REQ-013 SHALL have m_ready  in  1  consumer accepts CRC when m_valid & m_ready.
REQ-014 SHALL have m_crc  out  CW  final CRC (running CRC ^ XOROUT).
REQ-015 SHALL have err_framing  out  1  one-cycle pulse on framing error.

Function
REQ-016 SHALL implement states IDLE (no packet), BUSY (packet open), DONE (result held).
REQ-017 SHALL drive s_ready = 1 in IDLE and BUSY, 0 in DONE.
REQ-018 SHALL, on each accepted beat, update crc_reg <= CRC(s_data, seed), seed = INIT when s_sop=1 or state=IDLE, else crc_reg.
REQ-019 SHALL move IDLE->BUSY on an accepted beat with s_eop=0, and IDLE/BUSY->DONE on an accepted beat with s_eop=1.
REQ-020 SHALL, on entering DONE, register m_crc = new CRC ^ XOROUT and assert m_valid the following cycle (latency 1 cycle from eop accept).
REQ-021 SHALL hold m_valid and m_crc stable until m_valid & m_ready, then go DONE->IDLE; s_ready rises the cycle after.
REQ-022 SHALL treat a single beat with s_sop=1, s_eop=1 as a complete packet.
REQ-023 SHALL pulse err_framing for one cycle when a beat is accepted in IDLE with s_sop=0 (beat still processed with INIT seed).
REQ-024 SHALL pulse err_framing when a beat with s_sop=1 is accepted in BUSY; the open packet is discarded, CRC restarts from INIT.
REQ-025 SHALL ignore s_data/s_sop/s_eop whenever s_valid & s_ready is false; crc_reg unchanged.
REQ-026 SHALL NOT accept an input beat in the same cycle m_valid & m_ready occurs (no DONE bypass).

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, crc_reg=INIT, m_crc=0, m_valid=0, err_framing=0; s_ready=1 after reset.
REQ-028 SHALL abandon any packet in progress or pending result when reset asserts mid-operation; no CRC is emitted for it.

Structure
REQ-029 SHALL instantiate the existing combinational parallel CRC generator crc_gen_p (DW, CW, POLY) as its only sub-module for the per-beat update.
REQ-030 SHALL place the state enum (IDLE/BUSY/DONE) in shared package crc_pkg, together with named CRC preset constants (CRC8 0x07, CRC32 0x04C11DB7).
REQ-031 SHALL contain all sequential logic (state, crc_reg, m_crc, m_valid, err_framing) in crc_stream itself.

Verification
REQ-032 Defaults, 9 beats ASCII "123456789" (0x31..0x39), sop on first, eop on last, m_ready=1 -> m_crc=0xF4, m_valid one cycle after eop accept.
REQ-033 Defaults, single beat 0x01 sop+eop -> m_crc=0x07; single beat 0x00 sop+eop -> m_crc=0x00.
REQ-034 DW=8, CW=32, POLY=0x04C11DB7, INIT=0xFFFFFFFF, XOROUT=0, "123456789" -> m_crc=0x0376E6E7.
REQ-035 Defaults, eop accepted, m_ready held 0 for 5 cycles with s_valid=1 -> s_ready=0, m_crc stable 0xF4, no beat consumed; m_ready=1 -> IDLE, next packet starts.
REQ-036 Defaults, sop beat 0xAA, then sop beat 0x01 with eop -> err_framing pulses once, m_crc=0x07; beat 0x01 eop without sop in IDLE -> err_framing pulse, m_crc=0x07.
REQ-037 rst_n asserted mid-packet after 4 beats, released, then full "123456789" packet -> no output for aborted packet, then m_crc=0xF4.
